// File: rtl/fetch_tracer.sv
// Passive instruction-fetch tracer: follows the 8-clock bus cycle from sync,
// rebuilds each ROM fetch address/opcode and queues one 32-bit record per fetch.
module fetch_tracer #(
  parameter int DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        halt,
  input  logic        enable,
  input  logic [3:0]  data,
  input  logic        sync,
  input  logic        rom_cmd,
  output logic        rec_valid,
  output logic [31:0] rec_data,
  input  logic        rec_ready,
  output logic        overflow,
  output logic [7:0]  drop_count,
  input  logic        clear
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic [3:0] {
    ST_UNSYNC, ST_A1, ST_A2, ST_A3, ST_M1, ST_M2, ST_X1, ST_X2, ST_X3
  } state_t;

  state_t        state_q;
  logic [11:0]   addr_q;
  logic [3:0]    opc_hi_q;
  logic          cmd_q;
  logic [7:0]    seq_q, seq_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    drop_q, drop_d;
  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;

  logic          run, commit, pop, has_space, push, drop;
  logic [31:0]   record;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign run       = !halt;
  assign commit    = run && (state_q == ST_M2) && enable;
  assign pop       = rec_valid && rec_ready;
  // A pop on the same edge frees the slot the push needs.
  assign has_space = (count_q != FULL_CNT) || pop;
  assign push      = commit && has_space;
  assign drop      = commit && !has_space;
  assign record    = {cmd_q, 3'b000, addr_q, opc_hi_q, data, seq_q};

  always_comb begin
    seq_d      = seq_q;
    overflow_d = overflow_q;
    drop_d     = drop_q;
    if (clear) begin
      seq_d      = 8'd0;
      overflow_d = 1'b0;
      drop_d     = 8'd0;
    end else begin
      if (commit) seq_d = seq_q + 8'd1;
      if (drop) begin
        overflow_d = 1'b1;
        drop_d     = sat_inc8(drop_q);
      end
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_UNSYNC;
      seq_q      <= 8'd0;
      overflow_q <= 1'b0;
      drop_q     <= 8'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      if (run) begin
        if (sync) begin
          state_q <= ST_A1;
        end else begin
          case (state_q)
            ST_A1:   state_q <= ST_A2;
            ST_A2:   state_q <= ST_A3;
            ST_A3:   state_q <= ST_M1;
            ST_M1:   state_q <= ST_M2;
            ST_M2:   state_q <= ST_X1;
            ST_X1:   state_q <= ST_X2;
            ST_X2:   state_q <= ST_X3;
            default: state_q <= ST_UNSYNC;
          endcase
        end
      end
      seq_q      <= seq_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // Captured fields and FIFO storage carry no reset; validity lives in the control state.
  always_ff @(posedge clock) begin
    if (run) begin
      case (state_q)
        ST_A1:   addr_q[3:0]  <= data;
        ST_A2:   addr_q[7:4]  <= data;
        ST_A3: begin
          addr_q[11:8] <= data;
          cmd_q        <= rom_cmd;
        end
        ST_M1:   opc_hi_q     <= data;
        default: ;
      endcase
    end
    if (push) mem_q[wr_ptr_q] <= record;
  end

  assign rec_valid  = (count_q != '0);
  assign rec_data   = rec_valid ? mem_q[rd_ptr_q] : 32'h0;
  assign overflow   = overflow_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_fetch_tracer.sv
// Bench for fetch_tracer: directed scenarios plus randomized fetches, checked
// against a queue-based model of the trace FIFO, sequence and drop counters.
module tb_fetch_tracer;

  localparam int DEPTH = 8;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        halt = 1'b0, enable = 1'b1, sync = 1'b0, rom_cmd = 1'b0;
  logic        rec_ready = 1'b0, clear = 1'b0;
  logic [3:0]  data = 4'h0;
  logic        rec_valid, overflow;
  logic [31:0] rec_data;
  logic [7:0]  drop_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic [7:0]  seq_m = 8'd0;
  logic [7:0]  drop_m = 8'd0;
  logic        ovf_m = 1'b0;

  fetch_tracer #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n), .halt(halt), .enable(enable),
    .data(data), .sync(sync), .rom_cmd(rom_cmd),
    .rec_valid(rec_valid), .rec_data(rec_data), .rec_ready(rec_ready),
    .overflow(overflow), .drop_count(drop_count), .clear(clear)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Checks outputs against the model, applies this edge's effects to the model, advances one clock.
  task automatic tick(input bit m2, input logic [31:0] rec);
    chk32("rec_valid", {31'd0, rec_valid}, {31'd0, exp_q.size() != 0});
    if (exp_q.size() != 0) chk32("rec_data", rec_data, exp_q[0]);
    chk32("overflow", {31'd0, overflow}, {31'd0, ovf_m});
    chk32("drop_count", {24'd0, drop_count}, {24'd0, drop_m});
    if (rec_ready && exp_q.size() != 0) void'(exp_q.pop_front());
    if (m2 && enable) begin
      if (exp_q.size() < DEPTH) exp_q.push_back({rec[31:8], seq_m});
      else begin
        ovf_m  = 1'b1;
        drop_m = (drop_m == 8'hFF) ? drop_m : drop_m + 8'd1;
      end
      seq_m = seq_m + 8'd1;
    end
    if (clear) begin
      seq_m = 8'd0; ovf_m = 1'b0; drop_m = 8'd0;
    end
    @(posedge clock);
    #1;
  endtask

  function automatic logic pick_ready(input int mode, input bit at_m2);
    case (mode)
      0:       return 1'b0;
      1:       return 1'($urandom_range(0, 1));
      2:       return at_m2;
      default: return 1'b1;
    endcase
  endfunction

  // One instruction cycle: sync clock, A1..M2 carrying the fetch, X1, X2.
  task automatic fetch(input logic [11:0] a, input logic [7:0] o, input logic c,
                       input logic en, input int hph, input int hlen,
                       input int rmode, input int cph);
    logic [31:0] rec;
    rec = {c, 3'b000, a, o, 8'h00};
    for (int p = 0; p < 8; p++) begin
      if (p == hph) begin
        for (int h = 0; h < hlen; h++) begin
          halt = 1'b1; sync = 1'b0; clear = 1'b0; enable = en;
          data = 4'($urandom); rom_cmd = 1'($urandom);
          rec_ready = pick_ready(rmode, 1'b0);
          tick(1'b0, rec);
        end
      end
      halt = 1'b0; sync = (p == 0); enable = en; clear = (p == cph);
      rom_cmd = 1'($urandom);
      case (p)
        1:       data = a[3:0];
        2:       data = a[7:4];
        3:       begin data = a[11:8]; rom_cmd = c; end
        4:       data = o[7:4];
        5:       data = o[3:0];
        default: data = 4'($urandom);
      endcase
      rec_ready = pick_ready(rmode, p == 5);
      tick(p == 5, rec);
    end
    clear = 1'b0;
  endtask

  task automatic idle(input int n, input int rmode);
    for (int k = 0; k < n; k++) begin
      halt = 1'b0; sync = 1'b0; clear = 1'b0;
      data = 4'($urandom); rom_cmd = 1'($urandom);
      rec_ready = pick_ready(rmode, 1'b0);
      tick(1'b0, 32'h0);
    end
    rec_ready = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) begin
      halt = 1'b0; sync = 1'b0; clear = 1'b0; rec_ready = 1'b1;
      tick(1'b0, 32'h0);
    end
    rec_ready = 1'b0;
    chk32("drained_empty", {31'd0, rec_valid}, 32'd0);
  endtask

  task automatic fill(input int n);
    for (int k = 0; k < n; k++)
      fetch(12'($urandom), 8'($urandom), 1'($urandom), 1'b1, -1, 0, 0, -1);
  endtask

  initial begin
    // Reset values
    repeat (3) @(posedge clock);
    #1;
    chk32("rst_valid", {31'd0, rec_valid}, 32'd0);
    chk32("rst_data", rec_data, 32'h0);
    chk32("rst_ovf", {31'd0, overflow}, 32'd0);
    chk32("rst_drops", {24'd0, drop_count}, 32'd0);
    reset_n = 1'b1;
    idle(3, 0);

    // Single clean fetch
    fetch(12'h123, 8'hD4, 1'b1, 1'b1, -1, 0, 0, -1);
    chk32("first_record", rec_data, 32'h8123_D400);
    drain();

    // Ten back-to-back fetches into an 8-deep FIFO with no consumer
    clear = 1'b1; tick(1'b0, 32'h0); clear = 1'b0;
    fill(10);
    idle(1, 0);
    chk32("burst_ovf", {31'd0, overflow}, 32'd1);
    chk32("burst_drops", {24'd0, drop_count}, 32'd2);
    for (int i = 0; i < 8; i++) begin
      chk32("burst_valid", {31'd0, rec_valid}, 32'd1);
      chk32("burst_seq", {24'd0, rec_data[7:0]}, i);
      rec_ready = 1'b1;
      tick(1'b0, 32'h0);
    end
    rec_ready = 1'b0;
    chk32("burst_empty", {31'd0, rec_valid}, 32'd0);

    // Full FIFO with a pop on the commit edge
    fill(8);
    fetch(12'hABC, 8'h5E, 1'b0, 1'b1, -1, 0, 2, -1);
    chk32("fullpop_drops", {24'd0, drop_count}, 32'd2);
    idle(1, 0);
    for (int i = 0; i < 7; i++) begin
      rec_ready = 1'b1; tick(1'b0, 32'h0);
    end
    rec_ready = 1'b0;
    chk32("fullpop_last", rec_data, 32'h0ABC_5E12);
    drain();

    // Clear beats a drop on the same edge
    fill(8);
    fetch(12'h456, 8'h78, 1'b1, 1'b1, -1, 0, 0, 5);
    chk32("clrwin_ovf", {31'd0, overflow}, 32'd0);
    chk32("clrwin_drops", {24'd0, drop_count}, 32'd0);
    drain();
    fetch(12'h789, 8'h01, 1'b0, 1'b1, -1, 0, 0, -1);
    chk32("clrwin_seq", {24'd0, rec_data[7:0]}, 32'd0);
    drain();

    // Halt for 5 clocks in M1
    fetch(12'h123, 8'hD4, 1'b1, 1'b1, 4, 5, 0, -1);
    chk32("halt_record", rec_data, 32'h8123_D401);
    drain();

    // Partial fetch abandoned by a resync, then X3 without sync
    idle(2, 0);
    sync = 1'b1; data = 4'hF; tick(1'b0, 32'h0);
    sync = 1'b0; data = 4'hE; tick(1'b0, 32'h0);
    data = 4'hD; tick(1'b0, 32'h0);
    fetch(12'h9A5, 8'h3C, 1'b0, 1'b1, -1, 0, 0, -1);
    idle(12, 0);
    chk32("unsync_count", {31'd0, rec_valid}, 32'd1);
    chk32("resync_record", rec_data, 32'h09A5_3C02);
    drain();
    fetch(12'h0F0, 8'hA5, 1'b1, 1'b1, -1, 0, 0, -1);
    chk32("after_unsync", rec_data, 32'h80F0_A503);
    drain();

    // Asynchronous reset in A3 with records queued
    fill(3);
    sync = 1'b1; tick(1'b0, 32'h0);
    sync = 1'b0; data = 4'h1; tick(1'b0, 32'h0);
    data = 4'h2; tick(1'b0, 32'h0);
    data = 4'h3;
    #3;
    reset_n = 1'b0;
    #1;
    chk32("arst_valid", {31'd0, rec_valid}, 32'd0);
    chk32("arst_data", rec_data, 32'h0);
    exp_q.delete();
    seq_m = 8'd0; ovf_m = 1'b0; drop_m = 8'd0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    idle(2, 0);
    fetch(12'h321, 8'h9B, 1'b0, 1'b1, -1, 0, 0, -1);
    chk32("arst_seq", {24'd0, rec_data[7:0]}, 32'd0);
    drain();

    // Randomized traffic; clears only early so the sequence number wraps later
    for (int i = 0; i < 300; i++) begin
      int hph, rmode, cph;
      hph   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : -1;
      rmode = ($urandom_range(0, 7) == 0) ? 0 : (($urandom_range(0, 3) == 0) ? 3 : 1);
      cph   = (i < 40 && $urandom_range(0, 15) == 0) ? int'($urandom_range(0, 7)) : -1;
      fetch(12'($urandom), 8'($urandom), 1'($urandom),
            1'($urandom_range(0, 9) != 0), hph, int'($urandom_range(1, 4)), rmode, cph);
      if ($urandom_range(0, 9) == 0) idle(int'($urandom_range(1, 4)), 1);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_tracer.md
# fetch_tracer

Passive bus monitor on the 4-bit system bus, downstream of the cpu/rom/ram bus. It tracks the 8-clock instruction cycle (A1 A2 A3 M1 M2 X1 X2 X3) from `sync` and snoops `data` to rebuild each fetched 12-bit ROM address and 8-bit opcode. Each fetch becomes one 32-bit trace record, held in a small FIFO and drained by a valid/ready consumer (debug backdoor, trace UART). The block never drives the bus.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, 2..64.
- `clock`  in  1  system clock; all sampling on the rising edge.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `halt`  in  1  freezes phase tracking and capture, same as the bus agents; FIFO drain continues.
- `enable`  in  1  when low, completed fetches are discarded (not pushed, not counted as drops).
- `data`  in  4  snooped system data bus.
- `sync`  in  1  high for exactly the X3 clock of each instruction cycle.
- `rom_cmd`  in  1  CPU ROM command line, sampled in A3.
- `rec_valid`  out  1  head record available.
- `rec_data`  out  32  head record: [31] rom_cmd@A3, [30:28] 0, [27:16] addr[11:0], [15:8] opcode {OPR,OPA}, [7:0] sequence number.
- `rec_ready`  in  1  consumer accepts head when high with `rec_valid`.
- `overflow`  out  1  sticky; set on first dropped record.
- `drop_count`  out  8  saturating count of dropped records.
- `clear`  in  1  synchronous: clears `overflow`, `drop_count`, sequence counter; FIFO contents kept.

## Operation
- Phase tracker states: UNSYNC, A1, A2, A3, M1, M2, X1, X2, X3. Reset -> UNSYNC.
- Any state, `sync`=1 and not halted -> next state A1. Otherwise A1->A2->...->X2->X3. X3 without `sync` -> UNSYNC, discarding the partial record. UNSYNC stays until `sync`.
- Capture per state (only when `halt`=0): A1 addr[3:0]=data; A2 addr[7:4]; A3 addr[11:8] and cmd bit=`rom_cmd`; M1 opcode[7:4]; M2 opcode[3:0].
- Commit in M2: record = captured fields + current sequence number. If `enable`=0, discard. Else if FIFO has space (counting a same-edge pop) push and increment sequence (8-bit wrap 255->0). Else drop: `overflow`<=1, `drop_count`+=1 saturating at 255. Sequence still increments, so drops show as gaps.
- Halt: while `halt`=1, state, captures and pending commit hold; on release, resume in the same phase.
- FIFO: DEPTH entries, registered output, no bypass. Push and pop on the same edge when full: both happen, no drop. Push and pop on the same edge when empty: impossible (no bypass), push only.
- `clear` and a same-edge drop: clear wins.
- Reset mid-cycle: FIFO emptied, tracker to UNSYNC, partial record lost.

## Timing
- Reset values: `rec_valid`=0, `rec_data`=0, `overflow`=0, `drop_count`=0, sequence=0, state UNSYNC.
- A record enters the FIFO on the rising edge ending M2. `rec_valid` rises the following clock if the FIFO was empty, i.e. 5 clocks after the A1 edge.
- `rec_data` is stable while `rec_valid`=1 and `rec_ready`=0. A pop advances the head at the edge; the next entry is visible the next clock.
- Throughput: one record per 8 clocks maximum. Sustained `rec_ready`=1 never overflows.
- `overflow` and `drop_count` update on the edge ending M2 of the dropped fetch.

## Test plan
- Reset, one clean cycle, sync then A1..M2 = 4'h3,4'h2,4'h1,4'hD,4'h4, `rom_cmd`=1 in A3 -> `rec_data`=32'h8123_D400, `rec_valid` 5 clocks after A1.
- 10 back-to-back fetches, `rec_ready`=0, DEPTH=8 -> 8 records with seq 0..7, `overflow`=1, `drop_count`=2. Then drain -> seq 0..7 in order, then `rec_valid`=0.
- FIFO full and `rec_ready`=1 on the M2 commit edge -> no drop, `drop_count` unchanged, new record last in the FIFO.
- `halt`=1 for 5 clocks during M1 -> record identical to the unhalted case, committed 5 clocks later.
- X3 without `sync` after a partial fetch -> no push, state UNSYNC. Next `sync` -> normal capture resumes.
- Async reset asserted mid-A3 with 3 records queued -> `rec_valid`=0 immediately. After release and a fetch, that record has seq 0.
